// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with memory-ready stalls.
// Optional jump support is enabled by defining JUMP_EN.
module multicycle_control #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSrc,
   output logic [2:0]         ALUOp,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_dbg
);

   localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
   localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
   localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
   localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
   localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
   localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
   localparam logic [STATE_W-1:0] S_RTEXEC = STATE_W'(6);
   localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
   localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
   localparam logic [STATE_W-1:0] S_IEXEC  = STATE_W'(9);
   localparam logic [STATE_W-1:0] S_IWB    = STATE_W'(10);
`ifdef JUMP_EN
   localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(11);
   localparam logic [5:0]         OP_J     = 6'b000010;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   logic [STATE_W-1:0] state_q, state_d;
   logic [2:0]         imm_op_q, imm_op_d;

   logic [STATE_W-1:0] dec_next;
   logic [2:0]         dec_imm;
   logic               dec_legal;

   // Opcode decode: dispatch target, immediate ALU op and legality
   always_comb begin
      dec_next  = S_FETCH;
      dec_imm   = 3'b000;
      dec_legal = 1'b1;
      case (opcode)
         OP_LW, OP_SW: dec_next = S_MEMADR;
         OP_RTYPE:     dec_next = S_RTEXEC;
         OP_BEQ:       dec_next = S_BRANCH;
         OP_ADDI:      dec_next = S_IEXEC;
         OP_ORI:  begin dec_next = S_IEXEC; dec_imm = 3'b001; end
         OP_ANDI: begin dec_next = S_IEXEC; dec_imm = 3'b011; end
         OP_SLTI: begin dec_next = S_IEXEC; dec_imm = 3'b111; end
`ifdef JUMP_EN
         OP_J:         dec_next = S_JUMP;
`endif
         default:      dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FETCH;
         imm_op_q <= 3'b000;
      end else begin
         state_q  <= state_d;
         imm_op_q <= imm_op_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      imm_op_d = imm_op_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            state_d  = dec_next;
            imm_op_d = dec_imm;
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_RTEXEC: state_d = S_ALUWB;
         S_IEXEC:  state_d = S_IWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Reset overrides the decode so FETCH's MemRead cannot leak out during rst
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      ALUOp       = 3'b000;
      illegal_op  = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               PCWrite = mem_ready;
               IRWrite = mem_ready;
            end
            S_DECODE: begin
               ALUSrcB    = 2'b11;
               illegal_op = ~dec_legal;
            end
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_RTEXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 3'b010;
            end
            S_ALUWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 3'b110;
               PCWriteCond = 1'b1;
               PCSrc       = 2'b01;
            end
            S_IEXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ALUOp   = imm_op_q;
            end
            S_IWB:    RegWrite = 1'b1;
`ifdef JUMP_EN
            S_JUMP: begin
               PCWrite = 1'b1;
               PCSrc   = 2'b10;
            end
`endif
            default: ;
         endcase
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected outputs go through a scoreboard queue.
module tb_multicycle_control;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ORI  = 6'b001101;
   localparam logic [5:0] ANDI = 6'b001100;
   localparam logic [5:0] SLTI = 6'b001010;
   localparam logic [5:0] BAD  = 6'b111111;
   localparam logic [5:0] JMP  = 6'b000010;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUOp;
   logic [3:0] state_dbg;

   multicycle_control #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
      .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
      logic [1:0] asb, pcs;
      logic [2:0] aop;
      logic ill;
   } ov_t;

   ov_t obs;
   assign obs = {state_dbg, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp, illegal_op};

   ov_t sb[$];
   int  n_chk = 0;
   int  n_err = 0;

   // Expected outputs for each state, written from the state/output table
   function automatic ov_t ex(input int st, input bit rdy, input logic [2:0] imm, input bit ill);
      ov_t e;
      e = '0;
      e.st = 4'(st);
      case (st)
         0:  begin e.mr = 1; e.asb = 2'b01; e.pcw = rdy; e.irw = rdy; end
         1:  begin e.asb = 2'b11; e.ill = ill; end
         2:  begin e.asa = 1; e.asb = 2'b10; end
         3:  begin e.mr = 1; e.iord = 1; end
         4:  begin e.rw = 1; e.m2r = 1; end
         5:  begin e.mw = 1; e.iord = 1; end
         6:  begin e.asa = 1; e.aop = 3'b010; end
         7:  begin e.rw = 1; e.rd = 1; end
         8:  begin e.asa = 1; e.aop = 3'b110; e.pcwc = 1; e.pcs = 2'b01; end
         9:  begin e.asa = 1; e.asb = 2'b10; e.aop = imm; end
         10: e.rw = 1;
         11: begin e.pcw = 1; e.pcs = 2'b10; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                      input ov_t e, input string tag);
      ov_t want;
      rst = r;
      opcode = op;
      mem_ready = rdy;
      sb.push_back(e);
      @(negedge clk);
      want = sb.pop_front();
      n_chk++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      opcode = 6'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      cyc(1, LW, 1, '0, "rst_hold_rdy");
      cyc(1, LW, 0, '0, "rst_hold");

      // lw, no stall: 0,1,2,3,4 then FETCH
      cyc(0, LW, 1, ex(0, 1, 0, 0), "lw_fetch");
      cyc(0, LW, 1, ex(1, 0, 0, 0), "lw_decode");
      cyc(0, LW, 1, ex(2, 0, 0, 0), "lw_memadr");
      cyc(0, LW, 1, ex(3, 0, 0, 0), "lw_memrd");
      cyc(0, LW, 0, ex(4, 0, 0, 0), "lw_memwb");

      // R-type with one FETCH stall cycle
      cyc(0, RT, 0, ex(0, 0, 0, 0), "rt_fetch_stall");
      cyc(0, RT, 1, ex(0, 1, 0, 0), "rt_fetch");
      cyc(0, RT, 0, ex(1, 0, 0, 0), "rt_decode");
      cyc(0, RT, 0, ex(6, 0, 0, 0), "rt_exec");
      cyc(0, RT, 0, ex(7, 0, 0, 0), "rt_aluwb");

      // immediates: latched ALU op must follow each opcode
      cyc(0, SLTI, 1, ex(0, 1, 0, 0), "slti_fetch");
      cyc(0, SLTI, 0, ex(1, 0, 0, 0), "slti_decode");
      cyc(0, SLTI, 0, ex(9, 0, 3'b111, 0), "slti_iexec");
      cyc(0, SLTI, 0, ex(10, 0, 0, 0), "slti_iwb");
      cyc(0, ORI, 1, ex(0, 1, 0, 0), "ori_fetch");
      cyc(0, ORI, 0, ex(1, 0, 0, 0), "ori_decode");
      cyc(0, ORI, 0, ex(9, 0, 3'b001, 0), "ori_iexec");
      cyc(0, ORI, 0, ex(10, 0, 0, 0), "ori_iwb");
      cyc(0, ANDI, 1, ex(0, 1, 0, 0), "andi_fetch");
      cyc(0, ANDI, 0, ex(1, 0, 0, 0), "andi_decode");
      cyc(0, ANDI, 0, ex(9, 0, 3'b011, 0), "andi_iexec");
      cyc(0, ANDI, 0, ex(10, 0, 0, 0), "andi_iwb");
      cyc(0, ADDI, 1, ex(0, 1, 0, 0), "addi_fetch");
      cyc(0, ADDI, 0, ex(1, 0, 0, 0), "addi_decode");
      cyc(0, ADDI, 0, ex(9, 0, 3'b000, 0), "addi_iexec");
      cyc(0, ADDI, 0, ex(10, 0, 0, 0), "addi_iwb");

      // sw with three not-ready cycles in MEMWR
      cyc(0, SW, 1, ex(0, 1, 0, 0), "sw_fetch");
      cyc(0, SW, 0, ex(1, 0, 0, 0), "sw_decode");
      cyc(0, SW, 0, ex(2, 0, 0, 0), "sw_memadr");
      for (int i = 0; i < 3; i++)
         cyc(0, SW, 0, ex(5, 0, 0, 0), "sw_memwr_stall");
      cyc(0, SW, 1, ex(5, 0, 0, 0), "sw_memwr_ready");

      // beq
      cyc(0, BEQ, 1, ex(0, 1, 0, 0), "beq_fetch");
      cyc(0, BEQ, 0, ex(1, 0, 0, 0), "beq_decode");
      cyc(0, BEQ, 0, ex(8, 0, 0, 0), "beq_branch");

      // unrecognised opcode
      cyc(0, BAD, 1, ex(0, 1, 0, 0), "bad_fetch");
      cyc(0, BAD, 0, ex(1, 0, 0, 1), "bad_decode_illegal");

      // jump opcode
      cyc(0, JMP, 1, ex(0, 1, 0, 0), "j_fetch");
`ifdef JUMP_EN
      cyc(0, JMP, 0, ex(1, 0, 0, 0), "j_decode");
      cyc(0, JMP, 0, ex(11, 0, 0, 0), "j_jump");
`else
      cyc(0, JMP, 0, ex(1, 0, 0, 1), "j_decode_illegal");
`endif

      // reset asserted mid-stall in MEMRD
      cyc(0, LW, 1, ex(0, 1, 0, 0), "lw2_fetch");
      cyc(0, LW, 0, ex(1, 0, 0, 0), "lw2_decode");
      cyc(0, LW, 0, ex(2, 0, 0, 0), "lw2_memadr");
      cyc(0, LW, 0, ex(3, 0, 0, 0), "lw2_memrd_stall");
      cyc(1, LW, 1, '0, "rst_in_memrd");
      cyc(1, LW, 1, '0, "rst_in_memrd_hold");
      cyc(0, LW, 0, ex(0, 0, 0, 0), "post_rst_fetch_stall");
      cyc(0, LW, 1, ex(0, 1, 0, 0), "post_rst_fetch");
      cyc(0, LW, 0, ex(1, 0, 0, 0), "post_rst_decode");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL declare parameter STATE_W, default 4, the width of the state register and of the state_dbg port.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have input opcode, 6 bits: instruction bits [31:26], taken from the instruction register.
REQ-005 The block SHALL have input mem_ready, 1 bit: memory handshake; 1 means the current memory access completes this cycle.
REQ-006 The block SHALL drive these 1-bit outputs: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA.
REQ-007 The block SHALL drive 2-bit outputs ALUSrcB and PCSrc.
REQ-008 The block SHALL drive output ALUOp, 3 bits, which feeds the ALU control stage: 000 add, 001 or, 011 and, 110 sub, 111 slt, 010 R-type decode from funct.
REQ-009 The block SHALL drive output illegal_op, 1 bit: a one-cycle pulse on an unrecognised opcode.
REQ-010 The block SHALL drive output state_dbg, STATE_W bits: the current state encoding.

Function
REQ-011 The block SHALL be a Moore FSM: every output is a combinational decode of the state register and the latched immediate ALUOp only; mem_ready and opcode SHALL NOT reach any output other than through the gating defined in REQ-015 and REQ-017.
REQ-012 The block SHALL use this state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11; codes 12-15 SHALL return to FETCH on the next edge.
REQ-013 Every output not listed for a state SHALL be 0 in that state.
REQ-014 In FETCH the block SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000 and PCSrc=00.
REQ-015 In FETCH, PCWrite and IRWrite SHALL be 1 only in a cycle where mem_ready=1; the FSM SHALL stay in FETCH while mem_ready=0 and move to DECODE when mem_ready=1.
REQ-016 In DECODE the block SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=000, and SHALL branch on opcode:
- 100011 (lw) and 101011 (sw) -> MEMADR
- 000000 (R-type) -> RTEXEC
- 000100 (beq) -> BRANCH
- 001000 (addi), 001101 (ori), 001100 (andi), 001010 (slti) -> IEXEC
- any other opcode -> FETCH
REQ-017 On an unrecognised opcode in DECODE, illegal_op SHALL be 1 for exactly that cycle.
REQ-018 In DECODE the block SHALL latch the immediate ALUOp into an internal register: addi 000, ori 001, andi 011, slti 111, all other opcodes 000.
REQ-019 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=000, then go to MEMRD for lw or MEMWR for sw.
REQ-020 MEMRD SHALL drive MemRead=1 and IorD=1, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-021 MEMWB SHALL drive RegWrite=1, MemtoReg=1 and RegDst=0, then go to FETCH.
REQ-022 MEMWR SHALL drive MemWrite=1 and IorD=1, hold while mem_ready=0, and go to FETCH when mem_ready=1.
REQ-023 RTEXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=010, then go to ALUWB.
REQ-024 ALUWB SHALL drive RegWrite=1 and RegDst=1, then go to FETCH.
REQ-025 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=110, PCWriteCond=1 and PCSrc=01, then go to FETCH.
REQ-026 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp equal to the latched immediate ALUOp, then go to IWB.
REQ-027 IWB SHALL drive RegWrite=1, RegDst=0 and MemtoReg=0, then go to FETCH.
REQ-028 Latencies with no stall SHALL be: lw 5 cycles; sw, R-type and immediate 4 cycles; beq 3 cycles; each mem_ready=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.

Reset
REQ-029 While rst=1 the state SHALL be FETCH, the latched immediate ALUOp SHALL be 000, and every output except state_dbg SHALL be forced to 0, including mid-instruction and mid-stall.
REQ-030 On the first rising clk edge after rst falls, the block SHALL behave as FETCH.

Configuration
REQ-031 With macro JUMP_EN defined, opcode 000010 in DECODE SHALL go to JUMP, where PCWrite=1 and PCSrc=10, then to FETCH, giving a 3-cycle jump.
REQ-032 Without JUMP_EN, opcode 000010 SHALL be treated as illegal per REQ-016/REQ-017, PCSrc SHALL never equal 10, and state 11 SHALL be unreachable and handled as in REQ-012.

Verification
REQ-033 lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-034 R-type (000000) -> ALUOp=010 in RTEXEC, then RegWrite=1 with RegDst=1; slti (001010) -> ALUOp=111 in IEXEC.
REQ-035 sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 held for 4 cycles; FETCH reached after the ready cycle.
REQ-036 beq (000100) -> PCWriteCond=1, PCSrc=01, ALUOp=110 for exactly one cycle; FETCH follows.
REQ-037 Opcode 111111 -> illegal_op pulses once in DECODE, then FETCH; rst raised in MEMRD -> all outputs 0 immediately, state_dbg=0.
REQ-038 With JUMP_EN, opcode 000010 -> states 0,1,11,0 with PCWrite=1 and PCSrc=10 in state 11; without JUMP_EN -> illegal_op=1.
